// File: rtl/mux_sel_scanner.sv
// Display scanner: rotates the 4:1 mux select through enabled channels, dwelling CLK_DIV
// cycles per slot, with a matching active-low anode vector and a slot-advance strobe.
module mux_sel_scanner #(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned CNT_W   = $clog2(CLK_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       hold,
  input  logic [3:0] ch_mask,
  output logic [1:0] sel,
  output logic [3:0] an_n,
  output logic       slot_tick
);

  typedef enum logic {StIdle, StScan} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CLK_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_d;
  logic [3:0]       an_n_d;
  logic             tick_d;
  logic             active;
  logic             terminal;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Descending scan so the smallest offset wins; no other channel leaves sel unchanged.
  function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] c;
    r = cur;
    for (int i = 3; i >= 1; i--) begin
      c = cur + 2'(i);
      if (m[c]) r = c;
    end
    return r;
  endfunction

  assign active   = en && (ch_mask != 4'h0);
  assign terminal = (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sel       <= 2'd0;
      an_n      <= 4'hF;
      slot_tick <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel       <= sel_d;
      an_n      <= an_n_d;
      slot_tick <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (active) state_d = StScan;
      StScan:  if (!active) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel;
    an_n_d = an_n;
    tick_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        an_n_d = 4'hF;
        if (active) begin
          sel_d  = lowest_ch(ch_mask);
          an_n_d = ~((4'b0001 << sel_d) & ch_mask);
        end
      end
      StScan: begin
        if (!active) begin
          cnt_d  = '0;
          an_n_d = 4'hF;
        end else if (!hold) begin
          if (terminal) begin
            cnt_d  = '0;
            sel_d  = next_ch(sel, ch_mask);
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          an_n_d = ~((4'b0001 << sel_d) & ch_mask);
        end
      end
      default: begin
        cnt_d  = '0;
        an_n_d = 4'hF;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Scoreboard bench for mux_sel_scanner: a per-cycle reference model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_mux_sel_scanner;

  localparam int unsigned Div = 4;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] an_n;
    logic       tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] ch_mask = 4'h0;
  logic [1:0] sel;
  logic [3:0] an_n;
  logic       slot_tick;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   started = 1'b0;

  // Reference model state
  bit         m_scan = 1'b0;
  int         m_cnt = 0;
  int         m_sel = 0;
  logic [3:0] m_an = 4'hF;
  bit         m_tick = 1'b0;

  mux_sel_scanner #(.CLK_DIV(Div)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .hold      (hold),
    .ch_mask   (ch_mask),
    .sel       (sel),
    .an_n      (an_n),
    .slot_tick (slot_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] anode_for(input int s, input logic [3:0] m);
    logic [3:0] one;
    one = 4'b0001 << s;
    return m[s] ? ~one : 4'hF;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    m_tick = 1'b0;
    if (reset) begin
      m_scan = 1'b0; m_cnt = 0; m_sel = 0; m_an = 4'hF;
    end else if (!m_scan) begin
      m_an = 4'hF;
      if (en && ch_mask != 0) begin
        m_scan = 1'b1;
        m_cnt  = 0;
        for (int k = 3; k >= 0; k--) if (ch_mask[k]) m_sel = k;
        m_an = anode_for(m_sel, ch_mask);
      end
    end else if (!en || ch_mask == 0) begin
      m_scan = 1'b0; m_cnt = 0; m_an = 4'hF;
    end else if (!hold) begin
      if (m_cnt == Div - 1) begin
        int nxt;
        nxt = m_sel;
        for (int k = 4; k >= 1; k--) if (ch_mask[(m_sel + k) % 4]) nxt = (m_sel + k) % 4;
        m_sel  = nxt;
        m_cnt  = 0;
        m_tick = 1'b1;
      end else begin
        m_cnt++;
      end
      m_an = anode_for(m_sel, ch_mask);
    end
    e.sel  = 2'(m_sel);
    e.an_n = m_an;
    e.tick = m_tick;
    exp_q.push_back(e);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      if (exp_q.size() == 0) begin
        failures++;
        checks++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (sel !== e.sel) begin
          failures++;
          $display("FAIL sel at %0t: got %0d expected %0d", $time, sel, e.sel);
        end
        checks++;
        if (an_n !== e.an_n) begin
          failures++;
          $display("FAIL an_n at %0t: got %b expected %b", $time, an_n, e.an_n);
        end
        checks++;
        if (slot_tick !== e.tick) begin
          failures++;
          $display("FAIL slot_tick at %0t: got %b expected %b", $time, slot_tick, e.tick);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    step(1);
    // Full rotation
    en = 1'b1; ch_mask = 4'hF;
    step(20);
    // Alternating channels
    ch_mask = 4'b0101;
    step(16);
    // Hold mid-slot
    ch_mask = 4'hF;
    step(6);
    hold = 1'b1;
    step(10);
    hold = 1'b0;
    step(8);
    // Mask drops to zero, then single high channel
    ch_mask = 4'h0;
    step(3);
    ch_mask = 4'b1000;
    step(6);
    // Current channel masked off while others remain
    ch_mask = 4'b0011;
    step(10);
    // Reset mid-slot with en held high
    ch_mask = 4'hF;
    step(9);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(6);
    // Single channel, then en drop at a terminal count
    ch_mask = 4'b0010;
    step(13);
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(6);
    // Hold while idle has no effect
    en = 1'b0; hold = 1'b1;
    step(3);
    en = 1'b1;
    step(4);
    hold = 1'b0;
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 19) != 0);
      hold  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) ch_mask = 4'($urandom_range(0, 15));
      step(1);
    end
    reset = 1'b0; en = 1'b0; hold = 1'b0;
    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
